// File: rtl/vc_arbiter_router_pkg.sv
// Shared types and defaults for the VC arbiter/router: FSM state encoding and
// the default word geometry.
package vc_arbiter_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DATA_W_DEF    = 6;
  localparam int DEST_BIT_DEF  = 4;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/vc_arbiter_router_if.sv
// Handshake bundle between the two VC FIFOs, the router and the two destination FIFOs.
interface vc_arbiter_router_if
  import vc_arbiter_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              empty_VC0;
  logic              empty_VC1;
  logic [DATA_W-1:0] data_VC0;
  logic [DATA_W-1:0] data_VC1;
  logic              rd_VC0;
  logic              rd_VC1;
  logic              almost_full_D0;
  logic              almost_full_D1;
  logic              full_D0;
  logic              full_D1;
  logic              push_D0;
  logic              push_D1;
  logic [DATA_W-1:0] data_out;

  modport master (
    output empty_VC0, empty_VC1, data_VC0, data_VC1,
    output almost_full_D0, almost_full_D1, full_D0, full_D1,
    input  rd_VC0, rd_VC1, push_D0, push_D1, data_out
  );

  modport slave (
    input  empty_VC0, empty_VC1, data_VC0, data_VC1,
    input  almost_full_D0, almost_full_D1, full_D0, full_D1,
    output rd_VC0, rd_VC1, push_D0, push_D1, data_out
  );

endinterface

// File: rtl/vc_arbiter_router_vc_grant_rr.sv
// VC0-priority grant with a burst counter that forces a VC1 grant after
// MAX_BURST consecutive VC0 grants while VC1 is waiting.
module vc_grant_rr
  import vc_arbiter_router_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic empty_VC0,
  input  logic empty_VC1,
  output logic rd_VC0,
  output logic rd_VC1
);

  logic [3:0] burst_cnt;
  logic       give_vc1;

  always_comb begin
    give_vc1 = ~empty_VC1 & (empty_VC0 | (burst_cnt == 4'(MAX_BURST)));
    rd_VC1   = en & give_vc1;
    rd_VC0   = en & ~empty_VC0 & ~give_vc1;
  end

  // The count only matters while VC1 is waiting, so an empty VC1 clears it.
  always_ff @(posedge clk) begin
    if (rst || empty_VC1 || rd_VC1) begin
      burst_cnt <= 4'd0;
    end else if (rd_VC0 && (burst_cnt < 4'(MAX_BURST))) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/vc_arbiter_router.sv
// Pops VC0/VC1 one word per cycle and routes each word to D0 or D1 by a header
// bit; pauses on destination almost_full. Pop-to-push latency is two cycles.
module vc_arbiter_router
  import vc_arbiter_router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEST_BIT  = DEST_BIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  vc_arbiter_router_if.slave  bus,
  output logic                active,
  output logic                error
);

  state_t            state;
  state_t            next_state;
  logic              clr;
  logic              back_pressure;
  logic              grant_en;
  logic              vld_p0;
  logic              src_p0;
  logic [DATA_W-1:0] word_p0;
  logic              push_d0_p1;
  logic              push_d1_p1;
  logic [DATA_W-1:0] data_p1;

  assign clr           = reset | ~init;
  assign back_pressure = bus.almost_full_D0 | bus.almost_full_D1;
  assign grant_en      = (state == ARB) & ~back_pressure & ~clr;
  assign active        = (state == ARB);

  vc_grant_rr #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk       (clk),
    .rst       (clr),
    .en        (grant_en),
    .empty_VC0 (bus.empty_VC0),
    .empty_VC1 (bus.empty_VC1),
    .rd_VC0    (bus.rd_VC0),
    .rd_VC1    (bus.rd_VC1)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (!(bus.empty_VC0 && bus.empty_VC1)) next_state = ARB;
      ARB: begin
        if (back_pressure)                          next_state = HOLD;
        else if (bus.empty_VC0 && bus.empty_VC1)    next_state = IDLE;
      end
      HOLD: if (!back_pressure) next_state = ARB;
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: remember that a pop happened and which VC it came from.
  always_ff @(posedge clk) begin
    if (clr) vld_p0 <= 1'b0;
    else     vld_p0 <= bus.rd_VC0 | bus.rd_VC1;
  end

  always_ff @(posedge clk) begin
    src_p0 <= bus.rd_VC1;
  end

  assign word_p0 = src_p0 ? bus.data_VC1 : bus.data_VC0;

  // Stage p1: the FIFO read data is now valid; register the push and the word.
  always_ff @(posedge clk) begin
    if (clr) begin
      push_d0_p1 <= 1'b0;
      push_d1_p1 <= 1'b0;
      data_p1    <= '0;
    end else begin
      push_d0_p1 <= vld_p0 & ~word_p0[DEST_BIT];
      push_d1_p1 <= vld_p0 &  word_p0[DEST_BIT];
      if (vld_p0) data_p1 <= word_p0;
    end
  end

  assign bus.push_D0  = push_d0_p1;
  assign bus.push_D1  = push_d1_p1;
  assign bus.data_out = data_p1;

  always_ff @(posedge clk) begin
    if (clr) error <= 1'b0;
    else     error <= error | (push_d0_p1 & bus.full_D0) | (push_d1_p1 & bus.full_D1);
  end

endmodule
